// File: rtl/logic_gate_pkg.sv
// Shared types for the bitwise logic unit: operation labels and width defaults.
// The op enum also indexes the packed result array inside the top.
package logic_gate_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 64;
    localparam int NUM_OPS       = 5;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_XOR  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4
    } gate_op_e;

endpackage

// File: rtl/logic_gate_if.sv
// Operand/result bundle for logic_gate; the master drives operands, the slave returns results.
interface logic_gate_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [WIDTH-1:0] y4;
    logic [WIDTH-1:0] y5;

    modport master (
        output a, b,
        input  y1, y2, y3, y4, y5
    );

    modport slave (
        input  a, b,
        output y1, y2, y3, y4, y5
    );
endinterface

// File: rtl/logic_gate_comb.sv
// Purely combinational gate core; each bit lane is independent, so it is built per lane.
module logic_gate_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f1,
    output logic [WIDTH-1:0] f2,
    output logic [WIDTH-1:0] f3,
    output logic [WIDTH-1:0] f4,
    output logic [WIDTH-1:0] f5
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign f1[i] = a[i] & b[i];
        assign f2[i] = a[i] | b[i];
        assign f3[i] = a[i] ^ b[i];
        assign f4[i] = ~(a[i] & b[i]);
        assign f5[i] = ~(a[i] | b[i]);
    end
endmodule

// File: rtl/logic_gate.sv
// Registered five-function bitwise logic unit, one cycle of latency.
// Synchronous active-low reset clears every output, NAND/NOR included.
module logic_gate
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_gate_if.slave  bus
);
    logic [NUM_OPS-1:0][WIDTH-1:0] f;
    logic [NUM_OPS-1:0][WIDTH-1:0] y;

    logic_gate_comb #(.WIDTH(WIDTH)) u_comb (
        .a  (bus.a),
        .b  (bus.b),
        .f1 (f[GATE_AND]),
        .f2 (f[GATE_OR]),
        .f3 (f[GATE_XOR]),
        .f4 (f[GATE_NAND]),
        .f5 (f[GATE_NOR])
    );

    // Reset wins over the data update on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) y <= '0;
        else        y <= f;
    end

    assign bus.y1 = y[GATE_AND];
    assign bus.y2 = y[GATE_OR];
    assign bus.y3 = y[GATE_XOR];
    assign bus.y4 = y[GATE_NAND];
    assign bus.y5 = y[GATE_NOR];
endmodule

// File: tb/tb_logic_gate.sv
// Scoreboard bench for logic_gate: drivers push expected results, a monitor checks after each edge.
module tb_logic_gate;
    import logic_gate_pkg::*;

    typedef struct {
        logic [4:0][7:0] y;
        bit              inv;
        string           tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;
    exp_t q4[$];
    exp_t q8[$];
    logic [3:0] sweep[4] = '{4'b0000, 4'b1111, 4'b1010, 4'b0101};

    logic_gate_if #(.WIDTH(4)) bus4 ();
    logic_gate_if #(.WIDTH(8)) bus8 ();

    logic_gate #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    logic_gate #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth-table model indexed by {a,b} per bit.
    function automatic logic [3:0] gate4(gate_op_e op, logic [3:0] a, logic [3:0] b);
        logic [3:0] tt;
        logic [3:0] r;
        case (op)
            GATE_AND:  tt = 4'b1000;
            GATE_OR:   tt = 4'b1110;
            GATE_XOR:  tt = 4'b0110;
            GATE_NAND: tt = 4'b0111;
            GATE_NOR:  tt = 4'b0001;
            default:   tt = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic logic [4:0][7:0] model4(logic [3:0] a, logic [3:0] b);
        logic [4:0][7:0] r;
        for (int k = 0; k < 5; k++) r[k] = {4'b0000, gate4(gate_op_e'(k), a, b)};
        return r;
    endfunction

    function automatic logic [4:0][7:0] pack5(logic [7:0] y1, logic [7:0] y2, logic [7:0] y3,
                                              logic [7:0] y4, logic [7:0] y5);
        logic [4:0][7:0] r;
        r[0] = y1; r[1] = y2; r[2] = y3; r[3] = y4; r[4] = y5;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0][7:0] y, input bit inv, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n  = r;
        bus4.a = a;
        bus4.b = b;
        e.y = y; e.inv = inv; e.tag = tag;
        q4.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk({e.tag, "_y1"}, {4'b0, bus4.y1}, e.y[0]);
            chk({e.tag, "_y2"}, {4'b0, bus4.y2}, e.y[1]);
            chk({e.tag, "_y3"}, {4'b0, bus4.y3}, e.y[2]);
            chk({e.tag, "_y4"}, {4'b0, bus4.y4}, e.y[3]);
            chk({e.tag, "_y5"}, {4'b0, bus4.y5}, e.y[4]);
            if (e.inv) begin
                chk({e.tag, "_inv_nand"}, {4'b0, bus4.y4}, {4'b0, ~bus4.y1});
                chk({e.tag, "_inv_nor"},  {4'b0, bus4.y5}, {4'b0, ~bus4.y2});
                chk({e.tag, "_inv_xor"},  {4'b0, bus4.y3}, {4'b0, bus4.y2 & bus4.y4});
            end
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk({e.tag, "_w8_y1"}, bus8.y1, e.y[0]);
            chk({e.tag, "_w8_y2"}, bus8.y2, e.y[1]);
            chk({e.tag, "_w8_y3"}, bus8.y3, e.y[2]);
            chk({e.tag, "_w8_y4"}, bus8.y4, e.y[3]);
            chk({e.tag, "_w8_y5"}, bus8.y5, e.y[4]);
        end
    end

    initial begin
        exp_t e8;
        logic [3:0] ra;
        logic [3:0] rb;
        rst_n  = 1'b0;
        bus4.a = '0; bus4.b = '0;
        bus8.a = 8'hFF; bus8.b = 8'hFF;

        // Reset held for two edges with all-ones operands.
        step(1'b0, 4'b1111, 4'b1111, '0, 1'b0, "rst0");
        e8.y = '0; e8.inv = 1'b0; e8.tag = "rst0";
        q8.push_back(e8);
        step(1'b0, 4'b1111, 4'b1111, '0, 1'b0, "rst1");

        step(1'b1, 4'b1110, 4'b1000,
             pack5(8'h08, 8'h0E, 8'h06, 8'h07, 8'h01), 1'b1, "directed");

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                step(1'b1, sweep[i], sweep[j], model4(sweep[i], sweep[j]), 1'b1,
                     $sformatf("sweep_%0d_%0d", i, j));

        for (int n = 0; n < 50; n++) begin
            ra = 4'($urandom_range(1, 0));
            rb = 4'($urandom_range(1, 0));
            step(1'b1, ra, rb, model4(ra, rb), 1'b1, $sformatf("rand%0d", n));
        end

        // Mid-stream reset: one cleared edge, then data resumes on the next.
        step(1'b1, 4'b0011, 4'b0101, pack5(8'h01, 8'h07, 8'h06, 8'h0E, 8'h08), 1'b1, "mid_pre");
        step(1'b0, 4'b0011, 4'b0101, '0, 1'b0, "mid_rst");
        step(1'b1, 4'b0011, 4'b0101, pack5(8'h01, 8'h07, 8'h06, 8'h0E, 8'h08), 1'b1, "mid_post");

        @(negedge clk);
        bus8.a = 8'hF0;
        bus8.b = 8'h3C;
        e8.y = pack5(8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03); e8.inv = 1'b0; e8.tag = "param";
        q8.push_back(e8);

        repeat (3) @(negedge clk);
        chk("queues_drained", 8'(q4.size() + q8.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
